// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction-fetch stage.
//   RESET_PC_DEFAULT : fetch address used after reset unless overridden
//   INSTR_BYTES      : byte distance between consecutive instruction words
//   NOP              : canonical RISC-V nop (addi x0, x0, 0)
//   fetch_entry_t    : {pc, instr} pair handed to decode
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch entries between the memory response
// path and decode.
//   clk, rst_n  : clock, synchronous active-low reset (control state only)
//   push        : write push_entry at the tail (caller guarantees space)
//   push_entry  : entry to write
//   pop         : remove head; ignored when empty
//   flush       : empty the FIFO; overrides push and pop
//   head        : head entry, all zeros when empty
//   count       : number of valid entries (0..DEPTH)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction-fetch stage.
//   clk, rst_n       : clock, synchronous active-low reset
//   redirectValid    : reload fetch PC from redirectTarget, flush everything
//   redirectTarget   : new fetch PC (low two bits ignored)
//   imemReqValid/Ready/Addr : word request to instruction memory
//   imemRespValid/Data      : in-order responses, no backpressure
//   ifValid/Ready, ifPc, ifInstruction : buffered {pc, instr} toward decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        ifValid,
  input  logic        ifReady,
  output logic [31:0] ifPc,
  output logic [31:0] ifInstruction
);

  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] LIMIT   = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  logic [31:0]   req_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [31:0]   target;
  logic          req_fire;
  logic          resp_drop;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign target = redirectTarget & ~32'h3;

  // Credit check on registered state only: every in-flight request already
  // owns a buffer slot, so a response can never find the FIFO full.
  assign occupancy    = {1'b0, outstanding} + {1'b0, count};
  assign imemReqValid = rst_n && !redirectValid && (occupancy < LIMIT);
  assign imemReqAddr  = req_pc;
  assign req_fire     = imemReqValid && imemReqReady;

  // Responses to requests issued before a redirect are discarded, including
  // one that lands in the redirect cycle itself.
  assign resp_drop  = imemRespValid && (redirectValid || (drop_count != '0));
  assign push       = imemRespValid && !resp_drop;
  assign push_entry = '{pc: resp_pc, instr: imemRespData};
  assign pop        = ifReady && !redirectValid;

  always_comb begin
    outstanding_next = outstanding;
    case ({req_fire, imemRespValid})
      2'b10:   outstanding_next = outstanding + ONE;
      2'b01:   outstanding_next = outstanding - ONE;
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirectValid) begin
        req_pc     <= target;
        resp_pc    <= target;
        // Everything still in flight after this cycle's response is stale.
        drop_count <= imemRespValid ? (outstanding - ONE) : outstanding;
      end else begin
        if (req_fire) req_pc <= req_pc + PC_STEP;
        if (imemRespValid) begin
          if (drop_count != '0) drop_count <= drop_count - ONE;
          else                  resp_pc    <= resp_pc + PC_STEP;
        end
      end
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirectValid),
    .head       (head),
    .count      (count)
  );

  assign ifValid       = (count != '0);
  assign ifPc          = head.pc;
  assign ifInstruction = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: bench for fetch_stage. Plays the role of instruction memory
// (in-order responses, configurable latency, instruction = f(address)) and
// keeps a queue-level model of what decode must see.
module tb_fetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        ifValid;
  logic        ifReady;
  logic [31:0] ifPc;
  logic [31:0] ifInstruction;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .imemReqValid   (imemReqValid),
    .imemReqReady   (imemReqReady),
    .imemReqAddr    (imemReqAddr),
    .imemRespValid  (imemRespValid),
    .imemRespData   (imemRespData),
    .ifValid        (ifValid),
    .ifReady        (ifReady),
    .ifPc           (ifPc),
    .ifInstruction  (ifInstruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        live;
  } infl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } pop_t;

  infl_t       m_infl[$];
  logic [63:0] m_fifo[$];
  logic [31:0] m_reqpc;
  pop_t        pop_log[$];
  int          acc_log[$];
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          n_chk;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check request side,
  // then advance the model to what the next edge must produce.
  task automatic step(input logic r, input logic [31:0] t, input logic rr, input logic ir);
    logic        exp_v;
    logic        exp_rv;
    logic        resp_now;
    logic        accept;
    logic [31:0] acc_addr;
    infl_t       e;
    int          due;
    @(negedge clk);
    cyc++;
    exp_v = (m_fifo.size() != 0);
    chk("ifValid", ifValid, exp_v);
    chk("ifPc", ifPc, exp_v ? m_fifo[0][63:32] : 32'h0);
    chk("ifInstruction", ifInstruction, exp_v ? m_fifo[0][31:0] : 32'h0);

    redirectValid  = r;
    redirectTarget = t;
    imemReqReady   = rr;
    ifReady        = ir;
    resp_now       = (m_infl.size() != 0) && (m_infl[0].due == cyc);
    imemRespValid  = resp_now;
    imemRespData   = resp_now ? mem_word(m_infl[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !r && ((m_infl.size() + m_fifo.size()) < DEPTH);
    chk("imemReqValid", imemReqValid, exp_rv);
    chk("imemReqAddr", imemReqAddr, m_reqpc);
    accept   = imemReqValid && rr;
    acc_addr = imemReqAddr;

    if (ifValid && ir && !r) pop_log.push_back('{pc: ifPc, instr: ifInstruction, cyc: cyc});

    if (exp_v && ir && !r) void'(m_fifo.pop_front());
    if (resp_now) begin
      e = m_infl.pop_front();
      if (!r && e.live) m_fifo.push_back({e.addr, mem_word(e.addr)});
    end
    if (r) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].live = 1'b0;
      m_reqpc = t & ~32'h3;
    end else if (accept) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m_infl.push_back('{addr: acc_addr, due: due, live: 1'b1});
      acc_log.push_back(cyc);
      m_reqpc = m_reqpc + 32'd4;
      if (m_infl.size() > DEPTH) chk("outstanding_limit", m_infl.size(), DEPTH);
    end
  endtask

  initial begin
    int p0;
    int a0;
    int rcyc;
    n_chk = 0; n_fail = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    m_reqpc = 32'h0;
    rst_n = 1'b0; redirectValid = 1'b0; redirectTarget = 32'h0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0; ifReady = 1'b0;

    // Reset state.
    repeat (3) begin
      @(negedge clk);
      chk("rst_imemReqValid", imemReqValid, 32'h0);
      chk("rst_imemReqAddr", imemReqAddr, 32'h0);
      chk("rst_ifValid", ifValid, 32'h0);
      chk("rst_ifPc", ifPc, 32'h0);
      chk("rst_ifInstruction", ifInstruction, 32'h0);
    end
    rst_n = 1'b1;

    // Streaming, latency 1, always ready.
    p0 = pop_log.size(); a0 = acc_log.size();
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stream_pc0", pop_log[p0].pc, 32'h0000_0000);
    chk("stream_instr0", pop_log[p0].instr, 32'h5A5A_0013);
    chk("stream_pc1", pop_log[p0+1].pc, 32'h0000_0004);
    chk("stream_instr1", pop_log[p0+1].instr, 32'h5A5A_0017);
    chk("stream_first_latency", pop_log[p0].cyc - acc_log[a0], 2);
    chk("stream_back_to_back", pop_log[p0+1].cyc - pop_log[p0].cyc, 1);

    // Decode stalled: exactly DEPTH requests, head held.
    step(1'b1, 32'h0000_0200, 1'b1, 1'b0);
    a0 = acc_log.size(); p0 = pop_log.size();
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_requests", acc_log.size() - a0, DEPTH);
    chk("stall_reqvalid", imemReqValid, 32'h0);
    chk("stall_head_pc", ifPc, 32'h0000_0200);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("release_pc0", pop_log[p0].pc, 32'h0000_0200);
    chk("release_pc1", pop_log[p0+1].pc, 32'h0000_0204);
    chk("release_pc2", pop_log[p0+2].pc, 32'h0000_0208);
    chk("release_pc3", pop_log[p0+3].pc, 32'h0000_020C);
    chk("release_pc4", pop_log[p0+4].pc, 32'h0000_0210);

    // Redirect to 0x100 with three requests in flight (latency 4).
    lat_min = 4; lat_max = 4;
    step(1'b1, 32'h0000_0000, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
    a0 = acc_log.size();
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("inflight_before_redirect", acc_log.size() - a0, 3);
    p0 = pop_log.size();
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (14) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_pc0", pop_log[p0].pc, 32'h0000_0100);
    chk("redir_pc1", pop_log[p0+1].pc, 32'h0000_0104);

    // Redirect coinciding with a response and a pop (latency 2).
    lat_min = 2; lat_max = 2;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    p0 = pop_log.size();
    rcyc = cyc + 1;
    step(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    chk("redir_with_resp", imemRespValid, 32'h1);
    @(posedge clk); #1;
    chk("redir_ifvalid_next", ifValid, 32'h0);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir2_pc0", pop_log[p0].pc, 32'h0000_0300);
    chk("redir2_pc1", pop_log[p0+1].pc, 32'h0000_0304);
    chk("redir2_min_delay", (pop_log[p0].cyc - rcyc) >= 3, 32'h1);

    // Wrap-around at the top of the address space.
    lat_min = 1; lat_max = 1;
    p0 = pop_log.size();
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc0", pop_log[p0].pc, 32'hFFFF_FFFC);
    chk("wrap_pc1", pop_log[p0+1].pc, 32'h0000_0000);
    chk("wrap_pc2", pop_log[p0+2].pc, 32'h0000_0004);

    // Random traffic against the model.
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(15, 0) == 0);
      t = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      step(r, t, 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0));
    end
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline. Holds the fetch PC, issues word requests to instruction memory over a valid/ready handshake, matches in-order responses to their PCs, and buffers {pc, instruction} pairs toward decode, whose output feeds the branch-target generator and decoder. Redirects from branch/jump resolution reload the PC, flush buffered entries and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 4, entries in the fetch buffer; also the outstanding-request limit (power of two, ≥2)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- redirectValid  input  1  load new fetch PC this cycle
- redirectTarget  input  32  new fetch PC; bits [1:0] ignored (treated as 00)
- imemReqValid  output  1  request valid
- imemReqReady  input  1  memory accepts request
- imemReqAddr  output  32  word address of request
- imemRespValid  input  1  response valid; in request order, latency ≥1, no backpressure
- imemRespData  input  32  fetched instruction
- ifValid  output  1  buffer head valid toward decode
- ifReady  input  1  decode accepts head
- ifPc  output  32  PC of head entry
- ifInstruction  output  32  instruction of head entry

## Operation
- State: reqPc (next request address), respPc (PC of oldest live in-flight request), outstanding (0..BUF_DEPTH), dropCount (0..outstanding), FIFO of BUF_DEPTH {pc, instr}, count.
- Issue: imemReqValid = rst_n && !redirectValid && (outstanding + count < BUF_DEPTH), using registered values only (no same-cycle dequeue credit). imemReqAddr = reqPc. On acceptance reqPc += 4 (mod 2^32 wrap), outstanding += 1.
- Response: each imemRespValid decrements outstanding. If dropCount > 0, dropCount -= 1, data discarded. Else push {respPc, imemRespData}, respPc += 4. Credit rule guarantees space; overflow impossible.
- Dequeue: pop when ifValid && ifReady. ifValid = (count != 0). ifPc/ifInstruction = 0 when empty.
- Redirect (priority over all else): reqPc <= target, respPc <= target, FIFO cleared (count <= 0, pop ignored), no request issued, response arriving this cycle discarded, dropCount <= outstanding after this cycle's response decrement (i.e. outstanding − imemRespValid).
- Simultaneous accepted request + response: outstanding unchanged. Simultaneous push + pop: count unchanged.
- Reset: reqPc = respPc = RESET_PC, outstanding = dropCount = count = 0. Reset mid-operation: responses to pre-reset requests are not expected; memory is reset alongside.

## Timing
- Reset outputs: imemReqValid 0, imemReqAddr RESET_PC, ifValid 0, ifPc 0, ifInstruction 0.
- Request accepted cycle N, response cycle N+1 at earliest, ifValid cycle N+2 (FIFO registered, no bypass).
- Redirect asserted cycle R: ifValid 0 from R+1; first request to target issued R+1 (if memory ready); first target instruction at decode ≥ R+3.
- Sustained throughput 1 instr/cycle with response latency L when BUF_DEPTH ≥ L+2.

## Structure
- Shared package fetch_pkg: RESET_PC default, INSTR_BYTES = 4, NOP = 32'h0000_0013, entry type {pc[31:0], instr[31:0]}.
- One sub-module: fetch_buffer (synchronous FIFO, depth BUF_DEPTH, push/pop/flush, count output, zero-output when empty).

## Test plan
- Reset release, memory always ready, latency 1, ifReady=1 -> requests 0x0,0x4,0x8…; decode sees pc 0x0 with instr at cycle 2 after first acceptance, then one per cycle.
- ifReady held 0 -> exactly BUF_DEPTH requests issued, imemReqValid drops to 0, ifPc stays 0x0; release ifReady -> order preserved, no loss.
- Redirect to 0x100 with 3 requests in flight -> next 3 responses discarded, next pc seen at decode 0x100, then 0x104.
- Redirect in same cycle as response and pop -> that response dropped, ifValid 0 next cycle, dropCount = outstanding−1.
- redirectTarget 0xFFFF_FFFE -> fetches 0xFFFF_FFFC then wraps to 0x0000_0000.
- Random imemReqReady and response latency 1–5, random ifReady, random redirects -> decode PC stream matches reference model, never exceeds BUF_DEPTH outstanding.
